// File: rtl/cross_product_scheduler_pkg.sv
// Shared types and pipeline constants for the cross product scheduler.
// p_float is signed Q16.16 fixed point; p_float3 is an (x,y,z) vector.
package cross_product_scheduler_pkg;

    typedef logic signed [31:0] p_float;

    typedef struct packed {
        p_float x;
        p_float y;
        p_float z;
    } p_float3;

    localparam int FRAC_BITS    = 16;
    localparam int MULT_LATENCY = 2;
    localparam int ADD_LATENCY  = 1;
    localparam int XP_LATENCY   = MULT_LATENCY + ADD_LATENCY;

    function automatic p_float fx_mul(input p_float a, input p_float b);
        return 32'((64'(a) * 64'(b)) >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/cross_product.sv
// Pipelined c = a x b; MULT_LATENCY product stages then ADD_LATENCY stages.
// Registers are deliberately unreset; validity is tracked by the caller.
module cross_product
    import cross_product_scheduler_pkg::*;
(
    input  logic    clk,
    input  p_float3 a,
    input  p_float3 b,
    output p_float3 c
);

    p_float  prod [MULT_LATENCY][6];
    p_float3 sum  [ADD_LATENCY];

    always_ff @(posedge clk) begin
        prod[0][0] <= fx_mul(a.y, b.z);
        prod[0][1] <= fx_mul(a.z, b.y);
        prod[0][2] <= fx_mul(a.z, b.x);
        prod[0][3] <= fx_mul(a.x, b.z);
        prod[0][4] <= fx_mul(a.x, b.y);
        prod[0][5] <= fx_mul(a.y, b.x);
        for (int s = 1; s < MULT_LATENCY; s++) begin
            prod[s] <= prod[s-1];
        end
    end

    always_ff @(posedge clk) begin
        sum[0].x <= prod[MULT_LATENCY-1][0] - prod[MULT_LATENCY-1][1];
        sum[0].y <= prod[MULT_LATENCY-1][2] - prod[MULT_LATENCY-1][3];
        sum[0].z <= prod[MULT_LATENCY-1][4] - prod[MULT_LATENCY-1][5];
        for (int s = 1; s < ADD_LATENCY; s++) begin
            sum[s] <= sum[s-1];
        end
    end

    assign c = sum[ADD_LATENCY-1];

endmodule

// File: rtl/xp_result_fifo.sv
// First-word-fall-through result FIFO with synchronous reset.
module xp_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= bump(wptr);
            if (do_rd) rptr <= bump(rptr);
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cross_product_scheduler.sv
// Round-robin sharing of one cross_product pipeline among NUM_REQ requesters,
// with in-order, credit-protected result return.
module cross_product_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int XP_LATENCY = cross_product_scheduler_pkg::XP_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            req_valid,
    output logic [NUM_REQ-1:0]                            req_ready,
    input  cross_product_scheduler_pkg::p_float3 [NUM_REQ-1:0] req_a,
    input  cross_product_scheduler_pkg::p_float3 [NUM_REQ-1:0] req_b,
    output logic                                          rsp_valid,
    input  logic                                          rsp_ready,
    output cross_product_scheduler_pkg::p_float3          rsp_c,
    output logic [$clog2(NUM_REQ)-1:0]                    rsp_id,
    output logic                                          busy
);

    import cross_product_scheduler_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int CR_W = $clog2(FIFO_DEPTH + 1);
    localparam int FW   = $bits(p_float3) + ID_W;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            found;
    logic            issue;
    logic            pop;
    int              idx;
    logic [CR_W-1:0] credits;

    logic            s0_valid;
    logic [ID_W-1:0] s0_id;
    p_float3         s0_a;
    p_float3         s0_b;
    p_float3         xp_c;

    logic [XP_LATENCY-1:0] dl_valid;
    logic [ID_W-1:0]       dl_id [XP_LATENCY];

    logic          fifo_wr;
    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign issue = ~rst & (credits != '0) & found;
    assign pop   = rsp_valid & rsp_ready;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            credits  <= CR_W'(FIFO_DEPTH);
            s0_valid <= 1'b0;
            s0_id    <= '0;
            dl_valid <= '0;
            for (int k = 0; k < XP_LATENCY; k++) dl_id[k] <= '0;
        end else begin
            s0_valid <= issue;
            if (issue) begin
                s0_id  <= grant;
                rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (issue && !pop) begin
                credits <= credits - 1'b1;
            end else if (!issue && pop) begin
                credits <= credits + 1'b1;
            end
            dl_valid[0] <= s0_valid;
            dl_id[0]    <= s0_id;
            for (int k = 1; k < XP_LATENCY; k++) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_id[k]    <= dl_id[k-1];
            end
        end
    end

    // Operands hold when idle so the datapath inputs do not toggle.
    always_ff @(posedge clk) begin
        if (issue) begin
            s0_a <= req_a[grant];
            s0_b <= req_b[grant];
        end
    end

    cross_product u_xp (
        .clk (clk),
        .a   (s0_a),
        .b   (s0_b),
        .c   (xp_c)
    );

    assign fifo_wr  = dl_valid[XP_LATENCY-1];
    assign fifo_din = {xp_c, dl_id[XP_LATENCY-1]};

    xp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (fifo_wr),
        .din   (fifo_din),
        .rd    (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_c     = rsp_valid ? p_float3'(fifo_dout[FW-1:ID_W]) : '0;
    assign rsp_id    = rsp_valid ? fifo_dout[ID_W-1:0] : '0;
    assign busy      = (credits != CR_W'(FIFO_DEPTH));

    no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(fifo_wr && fifo_full)
    );

endmodule
